spi_reg_bank: RTL
=================

Name: spi_reg_bank

Overview:
- Downstream consumer of the SPI_COM slave's parallel receive byte (data_in) and source of its transmit byte (data_out).
- Oversamples SCK and CS in the system clock domain, counts bits, and frames bytes into a command/data protocol.
- Maintains a bank of 8-bit control registers that the SPI master can write and read back, plus one read-only status location.
- Sits between SPI_COM and the board control logic that consumes the register values.

Parameters:
- NUM_REGS, 8, number of read/write registers; addresses 0..NUM_REGS-1; legal range 1..127.
- STATUS_ADDR, 7'h7F, address of the read-only status_in location.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  system clock; must be at least 8x the SCK frequency.
- rst  input  1  synchronous reset, active-high.
- spi_sck  input  1  raw SCK, asynchronous to clk.
- spi_cs  input  1  raw CS, active-low, asynchronous to clk.
- spi_rx_byte  input  8  byte assembled by SPI_COM (its data_in).
- spi_tx_byte  output  8  byte SPI_COM shifts out on the next frame (its data_out).
- status_in  input  8  read-only status value, sampled when read.
- regs_flat  output  8*NUM_REGS  register contents; reg[i] is bits [8i+7:8i].
- wr_pulse  output  1  one-clk pulse on each committed register write.
- wr_addr  output  7  address of the last committed write.

Behaviour:
- Synchronisers:
  - spi_sck and spi_cs each pass through 2 flip-flops.
  - A rising edge of synchronised SCK (sck_rise) is detected with a third flop.
- Reset (rst=1 at a clk edge):
  - all registers = RESET_VAL;
  - spi_tx_byte = 8'h00, wr_pulse = 0, wr_addr = 0;
  - bit_cnt = 0, state = IDLE.
  - Reset takes priority over every other event, including a mid-frame reset. After reset, the block waits for CS high before accepting a new frame.
- Bit counter:
  - 3 bits; increments on sck_rise while synchronised CS is low.
  - On the sck_rise that makes bit_cnt wrap 7->0, byte_done pulses one clk later. That extra clk lets spi_rx_byte settle.
  - spi_rx_byte is captured on byte_done.
- State machine (states IDLE, CMD, WDATA, RDATA):
  - IDLE: CS high. CS low moves to CMD with bit_cnt = 0.
  - CMD, on byte_done: bit7 = 1 means read, 0 means write; addr = bits[6:0].
    - Write -> WDATA.
    - Read -> RDATA; spi_tx_byte is loaded with the value at addr within 1 clk of byte_done.
  - WDATA, on byte_done:
    - If addr < NUM_REGS: reg[addr] = byte, wr_pulse = 1 for one clk, wr_addr = addr.
    - Otherwise (including STATUS_ADDR): the write is dropped and wr_pulse stays 0.
    - addr then auto-increments.
  - RDATA, on byte_done: addr auto-increments and spi_tx_byte is reloaded with the value at the new addr.
  - Synchronised CS rising in any state: return to IDLE, bit_cnt = 0, discard any partial byte. Registers and spi_tx_byte are held.
- Read values:
  - addr < NUM_REGS returns reg[addr].
  - STATUS_ADDR returns status_in.
  - Any other address returns 8'h00.
- Address auto-increment:
  - NUM_REGS-1 wraps to 0.
  - STATUS_ADDR stays at STATUS_ADDR, so repeated status polling works within one frame.
  - Any other out-of-range address increments modulo 128.
- Simultaneous events: CS rising in the same clk as byte_done means the byte is discarded; no write occurs.
- regs_flat is registered and updates the clk after the write.

Optional Feature:
- Macro: SPI_ECHO_EN.
- Defined: in WDATA, spi_tx_byte is loaded on each byte_done with the byte just received, so the master reads back the previous byte as an echo. In CMD, spi_tx_byte is loaded with the command byte.
- Not defined: spi_tx_byte changes only in RDATA/CMD-read as specified, and holds its value during writes.

Test Plan:
- Reset: assert rst for 3 clks mid-frame -> every register = 8'h00, spi_tx_byte = 8'h00, wr_pulse = 0; next frame is decoded from CMD.
- Single write: frame 0x02, 0xA5 -> reg[2] = 0xA5, wr_pulse one clk, wr_addr = 2; other registers unchanged.
- Burst write with wrap, NUM_REGS = 8: frame 0x07, 0x11, 0x22 -> reg[7] = 0x11, reg[0] = 0x22; two wr_pulses.
- Read: after reg[3] = 0x5C and reg[4] = 0x3D, frame 0x83, dummy, dummy -> spi_tx_byte = 0x5C after byte 1, then 0x3D after byte 2.
- Status and out-of-range:
  - status_in = 0x9E, frame 0xFF, dummy, dummy -> spi_tx_byte = 0x9E twice.
  - Frame 0x20, 0x77 -> no write, no wr_pulse.
  - Frame 0xA0 -> spi_tx_byte = 0x00.
- CS abort: raise CS after 4 bits of the data byte in a write frame -> no write, state = IDLE; the next full frame 0x01, 0x42 writes reg[1] = 0x42.

Source files
------------

// File: rtl/spi_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_bank_if
// Brief    : SPI-side signal bundle between SPI_COM and spi_reg_bank.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_reg_bank_if;
    logic       spi_sck;
    logic       spi_cs;
    logic [7:0] spi_rx_byte;
    logic [7:0] spi_tx_byte;

    modport master (
        output spi_sck,
        output spi_cs,
        output spi_rx_byte,
        input  spi_tx_byte
    );

    modport slave (
        input  spi_sck,
        input  spi_cs,
        input  spi_rx_byte,
        output spi_tx_byte
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_bank
// Brief    : SPI command/data framer and 8-bit register bank with status
//            readback. Define SPI_ECHO_EN to echo received bytes on tx.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bank #(
    parameter int         NUM_REGS    = 8,
    parameter logic [6:0] STATUS_ADDR = 7'h7F,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    spi_reg_bank_if.slave              spi,
    input  wire logic [7:0]            status_in,
    output logic [8*NUM_REGS-1:0]      regs_flat,
    output logic                       wr_pulse,
    output logic [6:0]                 wr_addr
);

    localparam logic [7:0] c_NUM  = 8'(NUM_REGS);
    localparam logic [6:0] c_LAST = 7'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    logic       r_sck_meta, r_sck_sync, r_sck_prev;
    logic       r_cs_meta, r_cs_sync;
    logic [2:0] r_bit_cnt;
    logic       r_byte_done;
    logic       r_armed;
    state_t     r_state, w_state_nxt;
    logic [6:0] r_addr, w_addr_nxt, w_addr_inc;
    logic [7:0] r_tx, w_tx_nxt;
    logic       w_we;
    logic       w_sck_rise;

    function automatic logic [7:0] f_read(input logic [6:0]            a,
                                          input logic [8*NUM_REGS-1:0] flat,
                                          input logic [7:0]            stat);
        logic [7:0] v;
        v = 8'h00;
        if (a == STATUS_ADDR) v = stat;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == 7'(i)) v = flat[8*i +: 8];
        end
        return v;
    endfunction

    function automatic logic [6:0] f_inc(input logic [6:0] a);
        if (a == c_LAST)           return 7'd0;
        else if (a == STATUS_ADDR) return STATUS_ADDR;
        else                       return a + 7'd1;
    endfunction

    // Synchronisers run through reset so CS is already valid on release.
    always_ff @(posedge clk) begin
        r_sck_meta <= spi.spi_sck;
        r_sck_sync <= r_sck_meta;
        r_sck_prev <= r_sck_sync;
        r_cs_meta  <= spi.spi_cs;
        r_cs_sync  <= r_cs_meta;
    end

    assign w_sck_rise = r_sck_sync & ~r_sck_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
            r_armed     <= 1'b0;
        end else if (r_cs_sync) begin
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            r_bit_cnt   <= w_sck_rise ? r_bit_cnt + 3'd1 : r_bit_cnt;
            r_byte_done <= w_sck_rise && (r_bit_cnt == 3'd7);
        end
    end

    assign w_addr_inc = f_inc(r_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_tx_nxt    = r_tx;
        w_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Only an armed block (CS seen high since reset) opens a frame.
                if (r_armed && !r_cs_sync) w_state_nxt = S_CMD;
            end
            S_CMD: begin
                if (r_byte_done) begin
                    w_addr_nxt = spi.spi_rx_byte[6:0];
                    if (spi.spi_rx_byte[7]) begin
                        w_state_nxt = S_RDATA;
                        w_tx_nxt    = f_read(spi.spi_rx_byte[6:0], regs_flat, status_in);
                    end else begin
                        w_state_nxt = S_WDATA;
`ifdef SPI_ECHO_EN
                        w_tx_nxt    = spi.spi_rx_byte;
`endif
                    end
                end
            end
            S_WDATA: begin
                if (r_byte_done) begin
                    w_we       = ({1'b0, r_addr} < c_NUM);
                    w_addr_nxt = w_addr_inc;
`ifdef SPI_ECHO_EN
                    w_tx_nxt   = spi.spi_rx_byte;
`endif
                end
            end
            S_RDATA: begin
                if (r_byte_done) begin
                    w_addr_nxt = w_addr_inc;
                    w_tx_nxt   = f_read(w_addr_inc, regs_flat, status_in);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // CS high wins over a coincident byte_done: the byte is discarded.
        if (r_cs_sync) begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = r_addr;
            w_tx_nxt    = r_tx;
            w_we        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= 7'd0;
            r_tx     <= 8'h00;
            wr_pulse <= 1'b0;
            wr_addr  <= 7'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_tx     <= w_tx_nxt;
            wr_pulse <= w_we;
            if (w_we) wr_addr <= r_addr;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            logic [7:0] r_reg;
            always_ff @(posedge clk) begin
                if (rst)                             r_reg <= RESET_VAL;
                else if (w_we && r_addr == 7'(i))    r_reg <= spi.spi_rx_byte;
            end
            assign regs_flat[8*i +: 8] = r_reg;
        end
    endgenerate

    assign spi.spi_tx_byte = r_tx;

endmodule
`default_nettype wire
